// File: rtl/btn_debouncer.sv
// btn_debouncer: turns a raw, bouncing, asynchronous push-button into a clean level on clk.
// Latency: 2 clk sync + 1..DIV clk to first sample tick + (STABLE_CNT-1)*DIV clk qualification.
// Backpressure: none; free-running level output, o_long is a single-cycle pulse.
//
// Ports:
//   clk     - system clock
//   rst     - synchronous, active-high reset
//   i_btn   - raw button input, asynchronous to clk, may bounce
//   o_level - debounced level, changes only after STABLE_CNT consecutive agreeing samples
//   o_long  - 1-clk long-press pulse; constant 0 unless BTN_LONGPRESS_EN is defined
//
// Optional feature macro: BTN_LONGPRESS_EN builds the hold counter that drives o_long.
module btn_debouncer #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int SAMPLE_HZ  = 1_000,
   parameter int STABLE_CNT = 8,
   parameter int LONG_TICKS = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_long
);

   localparam int DIV = CLK_HZ / SAMPLE_HZ;
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CW  = $clog2(STABLE_CNT + 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(STABLE_CNT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Elaboration-time parameter sanity checks.
   if (DIV < 2) begin : g_bad_div
      $error("btn_debouncer: CLK_HZ/SAMPLE_HZ must be >= 2");
   end
   if (STABLE_CNT < 1) begin : g_bad_stable
      $error("btn_debouncer: STABLE_CNT must be >= 1");
   end
   if (LONG_TICKS < 1) begin : g_bad_long
      $error("btn_debouncer: LONG_TICKS must be >= 1");
   end

   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      S_RISE = 2'b01,
      S_HIGH = 2'b10,
      S_FALL = 2'b11
   } state_t;

   // ---------------- synchroniser ----------------
   logic sync1_q, sync2_q;
   logic btn_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= i_btn;
         sync2_q <= sync1_q;
      end
   end

   assign btn_s = sync2_q;

   // ---------------- sample-tick divider ----------------
   logic [DW-1:0] div_q, div_d;
   logic          tick;

   assign tick  = (div_q == DIV_LAST);
   assign div_d = tick ? '0 : div_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
   end

   // ---------------- stability FSM ----------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_LOW: begin
            if (tick) begin
               if (btn_s) begin
                  cnt_d   = CNT_ONE;
                  state_d = (STABLE_CNT == 1) ? S_HIGH : S_RISE;
               end else begin
                  cnt_d = '0;
               end
            end
         end
         S_RISE: begin
            if (tick) begin
               if (btn_s) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_d = S_HIGH;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  // One disagreeing sample throws away the partial qualification.
                  state_d = S_LOW;
                  cnt_d   = '0;
               end
            end
         end
         S_HIGH: begin
            if (tick) begin
               if (!btn_s) begin
                  cnt_d   = CNT_ONE;
                  state_d = (STABLE_CNT == 1) ? S_LOW : S_FALL;
               end else begin
                  cnt_d = '0;
               end
            end
         end
         S_FALL: begin
            if (tick) begin
               if (!btn_s) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_d = S_LOW;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = S_HIGH;
                  cnt_d   = '0;
               end
            end
         end
         // Recover from any corrupted encoding without waiting for a tick.
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Level is decoded straight from the state register, so it moves on the qualifying tick edge.
   assign o_level = (state_q == S_HIGH) || (state_q == S_FALL);

   // ---------------- optional long-press detector ----------------
`ifdef BTN_LONGPRESS_EN
   localparam int HW = $clog2(LONG_TICKS + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

   logic [HW-1:0] hold_q, hold_d;
   logic [HW-1:0] hold_inc;
   logic          long_q, long_d;

   assign hold_inc = hold_q + 1'b1;

   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == S_LOW) begin
         hold_d = '0;
      end else if (tick && o_level && (hold_q != HOLD_MAX)) begin
         // Saturating count: the pulse can only fire once per press.
         hold_d = hold_inc;
         long_d = (hold_inc == HOLD_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign o_long = long_q;
`else
   assign o_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debouncer.sv
// tb_btn_debouncer: randomized and directed stimulus for btn_debouncer, scoreboard-checked.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_btn_debouncer;

   localparam int CLK_HZ     = 1000;
   localparam int SAMPLE_HZ  = 100;
   localparam int DIV        = CLK_HZ / SAMPLE_HZ;
   localparam int STABLE     = 4;
   localparam int LONG       = 20;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic i_btn = 1'b1;
   logic o_level;
   logic o_long;

   always #5 clk = ~clk;

   btn_debouncer #(
      .CLK_HZ    (CLK_HZ),
      .SAMPLE_HZ (SAMPLE_HZ),
      .STABLE_CNT(STABLE),
      .LONG_TICKS(LONG)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (i_btn),
      .o_level(o_level),
      .o_long (o_long)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit mon_en  = 1'b0;

   typedef struct {
      bit val;
      int cyc;
   } ev_t;

   ev_t lvl_q[$];
   int  long_q[$];
   int  level_changes = 0;
   int  long_pulses   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ---------------- reference model ----------------
   // Behavioural rule: at every sample tick the synchronised input is appended to a
   // window of the last STABLE samples; the level flips when the whole window agrees
   // on the opposite value. Ticks fall on every DIV-th clock counted from reset release.
   bit m_level = 1'b0;
   int m_k     = 0;
   int m_hold  = 0;
   bit hist[$] = '{1'b0, 1'b0};
   bit win[$];

   always @(posedge clk) begin
      bit   s;
      bit   all_eq;
      ev_t  e;
      cyc++;
      s = hist[0];                       // input as seen two edges ago
      hist.push_back(rst ? 1'b0 : i_btn);
      void'(hist.pop_front());
      if (rst) begin
         if (m_level) begin
            e.val = 1'b0;
            e.cyc = cyc;
            lvl_q.push_back(e);
         end
         m_level = 1'b0;
         m_k     = 0;
         m_hold  = 0;
         hist    = '{1'b0, 1'b0};
         win.delete();
      end else begin
         if ((m_k % DIV) == DIV - 1) begin
            if (m_level) begin
               m_hold++;
`ifdef BTN_LONGPRESS_EN
               if (m_hold == LONG) long_q.push_back(cyc);
`endif
            end
            win.push_back(s);
            if (win.size() > STABLE) void'(win.pop_front());
            if (win.size() == STABLE && s != m_level) begin
               all_eq = 1'b1;
               foreach (win[i]) if (win[i] != s) all_eq = 1'b0;
               if (all_eq) begin
                  m_level = s;
                  e.val   = s;
                  e.cyc   = cyc;
                  lvl_q.push_back(e);
                  if (!s) m_hold = 0;
               end
            end
         end
         m_k++;
      end
   end

   // ---------------- monitor ----------------
   bit prev_lvl = 1'b0;

   always @(negedge clk) begin
      ev_t e;
      int  lc;
      if (mon_en) begin
         if (o_level !== prev_lvl) begin
            level_changes++;
            if (lvl_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL level_unexpected: o_level=%b at cycle %0d, no change expected", o_level, cyc);
            end else begin
               e = lvl_q.pop_front();
               check("level_value", int'(o_level), int'(e.val));
               check("level_cycle", cyc, e.cyc);
            end
            prev_lvl = o_level;
         end
         if (o_long !== 1'b0) begin
            long_pulses++;
            if (long_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL long_unexpected: o_long=%b at cycle %0d, no pulse expected", o_long, cyc);
            end else begin
               lc = long_q.pop_front();
               check("long_cycle", cyc, lc);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_level(input string name, input bit v, input int bound, output int n);
      n = 0;
      while (o_level !== v && n < bound) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_reached"}, int'(o_level), int'(v));
   endtask

   int n;
   int c0;
   int p0;

   initial begin
      // 1. reset held with button pressed
      rst   = 1'b1;
      i_btn = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      check("t1_rst_level", int'(o_level), 0);
      check("t1_rst_long", int'(o_long), 0);
      clks(2);
      check("t1_rst_level_3", int'(o_level), 0);
      check("t1_rst_long_3", int'(o_long), 0);
      rst   = 1'b0;
      i_btn = 1'b0;
      clks(1);
      check("t1_post_level", int'(o_level), 0);
      check("t1_post_long", int'(o_long), 0);
      clks(60);

      // 2. clean rising step
      i_btn = 1'b1;
      wait_level("t2", 1'b1, 60, n);
      check_range("t2_rise_latency", n, 33, 42);
      clks(20);
      i_btn = 1'b0;
      wait_level("t2_fall", 1'b0, 60, n);
      check_range("t2_fall_latency", n, 33, 42);
      clks(20);

      // 3. periodic bounce then hold high
      c0 = level_changes;
      for (int i = 0; i < 10; i++) begin
         i_btn = ~i_btn;
         clks(7);
      end
      check("t3_no_change_during_bounce", level_changes - c0, 0);
      i_btn = 1'b1;
      wait_level("t3", 1'b1, 42, n);
      clks(30);
      check("t3_single_rise", level_changes - c0, 1);

      // 4. short glitch from settled low
      i_btn = 1'b0;
      wait_level("t4_settle", 1'b0, 60, n);
      clks(20);
      c0 = level_changes;
      i_btn = 1'b1;
      clks(3);
      i_btn = 1'b0;
      clks(100);
      check("t4_glitch_changes", level_changes - c0, 0);
      check("t4_glitch_level", int'(o_level), 0);

      // 5. settled press, bouncy release (bounce kept shorter than one qualification window)
      i_btn = 1'b1;
      wait_level("t5_press", 1'b1, 60, n);
      clks(20);
      c0 = level_changes;
      for (int i = 0; i < 5; i++) begin
         i_btn = ~i_btn;
         clks($urandom_range(1, 5));
      end
      i_btn = 1'b0;
      wait_level("t5_release", 1'b0, 42, n);
      clks(40);
      check("t5_single_fall", level_changes - c0, 1);

      // 6. reset in the middle of a rising qualification
      rst = 1'b1;
      clks(1);
      rst   = 1'b0;
      i_btn = 1'b1;
      clks(25);
      check("t6_mid_rise_level", int'(o_level), 0);
      rst = 1'b1;
      clks(1);
      check("t6_rst_level", int'(o_level), 0);
      rst = 1'b0;
      wait_level("t6", 1'b1, 60, n);
      check("t6_requalify_cycles", n, 40);

      // 7. long press and short press
      i_btn = 1'b0;
      wait_level("t7_settle", 1'b0, 60, n);
      clks(20);
      p0 = long_pulses;
      i_btn = 1'b1;
      wait_level("t7_press", 1'b1, 60, n);
`ifdef BTN_LONGPRESS_EN
      n = 0;
      while (o_long !== 1'b1 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("t7_long_delay", n, 200);
      clks(100);
      check("t7_one_pulse", long_pulses - p0, 1);
`else
      clks(300);
      check("t7_no_long_when_disabled", long_pulses - p0, 0);
`endif
      i_btn = 1'b0;
      wait_level("t7_release", 1'b0, 60, n);
      clks(20);
      p0 = long_pulses;
      i_btn = 1'b1;
      clks(150);
      i_btn = 1'b0;
      wait_level("t7_short_release", 1'b0, 60, n);
      clks(20);
      check("t7_short_no_pulse", long_pulses - p0, 0);

      // 8. random bounce-like segments, checked purely by the scoreboard
      for (int i = 0; i < 40; i++) begin
         i_btn = 1'($urandom_range(0, 1));
         clks($urandom_range(1, 45));
      end
      i_btn = 1'b0;
      clks(100);

      check("final_level_queue_empty", lvl_q.size(), 0);
      check("final_long_queue_empty", long_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
